// File: rtl/w_input_conditioner.sv
// ----------------------------------------------------------------------------
// w_input_conditioner
//
// Front end for the sequence-detector FSM. It takes an asynchronous raw input
// (a switch or a pin), brings it into the Clk domain with a two-flop
// synchroniser, and debounces it with a four-state FSM and a small saturating
// counter. The result is a glitch-free level W plus one-cycle edge pulses.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive identical synchronised samples needed before
//                     a level change is accepted (legal 2 .. 2**CNT_W-1).
//   CNT_W           : width of the debounce counter.
//
// Ports
//   Clk    in  : system clock, all state changes on the rising edge.
//   Reset  in  : synchronous, active-high reset.
//   RawIn  in  : asynchronous raw input.
//   W      out : debounced level, connects to the detector's w input.
//   WRise  out : one-cycle pulse in the first cycle of W=1.
//   WFall  out : one-cycle pulse in the first cycle of W=0.
//   Stable out : 1 when no level change is pending (FSM in LOW or HIGH).
// ----------------------------------------------------------------------------
module w_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic RawIn,
  output logic W,
  output logic WRise,
  output logic WFall,
  output logic Stable
);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  // The counter holds how many agreeing samples have been seen so far in a
  // check state. The change is accepted on the sample that would bring it to
  // DEBOUNCE_CYCLES, so it never has to hold more than DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Synchroniser. Only s2_reg is allowed to feed the FSM; s1_reg may be
  // metastable and RawIn must never reach the logic combinationally.
  logic s1_reg;
  logic s2_reg;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  logic w_reg,      w_next;
  logic rise_reg,   rise_next;
  logic fall_reg,   fall_next;
  logic stable_reg, stable_next;

  // --------------------------------------------------------------------------
  // State register: synchroniser, FSM state, counter and registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      state_reg  <= ST_LOW;
      cnt_reg    <= CNT_ZERO;
      w_reg      <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      stable_reg <= 1'b1;
    end else begin
      s1_reg     <= RawIn;
      s2_reg     <= s1_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      w_reg      <= w_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      stable_reg <= stable_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // Entering a check state loads the counter with 1 because the sample that
  // caused the transition already counts as the first agreeing sample.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_LOW: begin
        if (s2_reg) begin
          state_next = ST_CHK_HI;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      ST_CHK_HI: begin
        if (!s2_reg) begin
          // Sample disagreed: glitch rejected, back to the settled level.
          state_next = ST_LOW;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_HIGH;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_reg) begin
          state_next = ST_CHK_LO;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      ST_CHK_LO: begin
        if (s2_reg) begin
          state_next = ST_HIGH;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_LOW;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_LOW;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic, computed from the transition being taken so the registered
  // outputs change on the same edge the FSM settles. Returning to the old
  // level from a check state (CHK_HI->LOW, CHK_LO->HIGH) produces no pulse,
  // and only one of the two accepting transitions can fire per cycle, so the
  // pulses are mutually exclusive.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = w_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    stable_next = (state_next == ST_LOW) || (state_next == ST_HIGH);
    if ((state_reg == ST_CHK_HI) && (state_next == ST_HIGH)) begin
      w_next    = 1'b1;
      rise_next = 1'b1;
    end
    if ((state_reg == ST_CHK_LO) && (state_next == ST_LOW)) begin
      w_next    = 1'b0;
      fall_next = 1'b1;
    end
  end

  assign W      = w_reg;
  assign WRise  = rise_reg;
  assign WFall  = fall_reg;
  assign Stable = stable_reg;

endmodule

// File: tb/tb_w_input_conditioner.sv
// ----------------------------------------------------------------------------
// Testbench for w_input_conditioner (DEBOUNCE_CYCLES=4).
// Each scenario starts with two reset edges, then edges are numbered 1..N
// from the first non-reset edge. The stimulus process drives RawIn/Reset
// before each edge and pushes the hand-derived outputs expected after that
// edge; a separate monitor pops one entry per edge and compares.
// ----------------------------------------------------------------------------
module tb_w_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_in = 1'b0;
  logic w, w_rise, w_fall, stable;

  always #5 clk = ~clk;

  w_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .RawIn (raw_in),
    .W     (w),
    .WRise (w_rise),
    .WFall (w_fall),
    .Stable(stable)
  );

  typedef struct {
    int         scn;
    int         edge_no;
    logic [3:0] v;       // {W, WRise, WFall, Stable}
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam int NUM_SCN = 5;

  function automatic int len_of(input int scn);
    case (scn)
      0: return 30;
      1: return 14;
      2: return 20;
      3: return 16;
      default: return 22;
    endcase
  endfunction

  function automatic logic raw_of(input int scn, input int e);
    logic [0:8] pat;
    pat = 9'b101101111;  // bounce pattern on edges 3..11
    case (scn)
      0: return (e >= 3) && (e <= 19);
      1: return (e >= 3) && (e <= 5);
      2: begin
        if (e < 3)   return 1'b0;
        if (e >= 12) return 1'b1;
        return pat[e-3];
      end
      default: return (e >= 3);
    endcase
  endfunction

  function automatic logic reset_of(input int scn, input int e);
    case (scn)
      3: return (e == 6);
      4: return (e == 12);
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs after edge e, worked out by hand from the timing rules:
  // a RawIn value sampled at edge k is seen by the FSM at edge k+2.
  function automatic logic [3:0] exp_of(input int scn, input int e);
    logic ew, er, ef, es;
    ew = 1'b0; er = 1'b0; ef = 1'b0; es = 1'b1;
    case (scn)
      0: begin  // clean rise then clean fall
        ew = (e >= 8) && (e <= 24);
        er = (e == 8);
        ef = (e == 25);
        es = !(((e >= 5) && (e <= 7)) || ((e >= 22) && (e <= 24)));
      end
      1: begin  // three-sample glitch rejected
        es = !((e >= 5) && (e <= 7));
      end
      2: begin  // bounce then settle
        ew = (e >= 13);
        er = (e == 13);
        es = !((e == 5) || (e == 7) || (e == 8) || ((e >= 10) && (e <= 12)));
      end
      3: begin  // reset in CHK_HI at edge 6
        ew = (e >= 12);
        er = (e == 12);
        es = !((e == 5) || ((e >= 9) && (e <= 11)));
      end
      default: begin  // reset while high at edge 12
        ew = ((e >= 8) && (e <= 11)) || (e >= 18);
        er = (e == 8) || (e == 18);
        es = !(((e >= 5) && (e <= 7)) || ((e >= 15) && (e <= 17)));
      end
    endcase
    return {ew, er, ef, es};
  endfunction

  task automatic push_exp(input int scn, input int e, input logic [3:0] v);
    exp_t x;
    x.scn = scn;
    x.edge_no = e;
    x.v = v;
    exp_q.push_back(x);
  endtask

  task automatic cmp(input string name, input int scn, input int e,
                     input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s scn=%0d edge=%0d got=%b want=%b", name, scn, e, got, want);
    end
  endtask

  // Monitor: the DUT presents a fresh output vector after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        cmp("W",      x.scn, x.edge_no, w,      x.v[3]);
        cmp("WRise",  x.scn, x.edge_no, w_rise, x.v[2]);
        cmp("WFall",  x.scn, x.edge_no, w_fall, x.v[1]);
        cmp("Stable", x.scn, x.edge_no, stable, x.v[0]);
        $display("scn=%0d edge=%0d W=%b WRise=%b WFall=%b Stable=%b",
                 x.scn, x.edge_no, w, w_rise, w_fall, stable);
      end
    end
  end

  // Stimulus
  initial begin
    for (int scn = 0; scn < NUM_SCN; scn++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        reset  = 1'b1;
        raw_in = 1'b0;
        push_exp(scn, -1 + k - 1, 4'b0001);
      end
      for (int e = 1; e <= len_of(scn); e++) begin
        @(negedge clk);
        reset  = reset_of(scn, e);
        raw_in = raw_of(scn, e);
        push_exp(scn, e, exp_of(scn, e));
      end
    end
    @(negedge clk);
    reset  = 1'b0;
    raw_in = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
